// File: rtl/bmp_frame_streamer.sv
// Streams a bottom-up 24-bit BMP from byte-wide frame memory as a top-down pixel stream.
// Byte reads are throttled so buffered plus in-flight pixels never exceed FIFO_DEPTH.
module bmp_frame_streamer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] img_width,
    input  logic [15:0] img_height,
    output logic        busy,
    output logic        done,
    output logic        mem_rd_en,
    output logic [31:0] mem_rd_addr,
    input  logic [7:0]  mem_rd_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [23:0] m_data,
    output logic        m_sof,
    output logic        m_eol,
    output logic        m_eof
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] stride_in, first_row;
    logic [31:0] stride, row_bytes, row_addr, col_off;
    logic [15:0] height_q, row_cnt;
    logic [1:0]  phase, ret_phase;
    logic        ret_valid;
    logic [2:0]  ret_flags;
    logic [7:0]  b_q, g_q;
    logic [CW-1:0] fifo_cnt, fifo_cnt_nxt, inflight, inflight_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [26:0] fifo_mem [FIFO_DEPTH];
    logic [26:0] head;
    logic        rd_go, last_col, last_row, last_byte, zero_dim;
    logic        push, pop;
    logic        sof_i, eol_i, eof_i;

    always_comb begin
        stride_in = ((32'(img_width) * 32'd3) + 32'd3) & ~32'd3;
        first_row = base_addr + (32'(img_height) - 32'd1) * stride_in;
        zero_dim  = (img_width == 16'd0) || (img_height == 16'd0);

        last_col  = (col_off == row_bytes - 32'd1);
        last_row  = (row_cnt == height_q - 16'd1);
        last_byte = last_col && last_row;
        sof_i     = (row_cnt == 16'd0) && (col_off == 32'd2);
        eol_i     = last_col;
        eof_i     = last_byte;

        // Throttle on every byte, so a stalled FIFO can pause a pixel mid-read.
        rd_go = (state == RUN) && ((fifo_cnt + inflight) < CW'(FIFO_DEPTH));
        push  = ret_valid && (ret_phase == 2'd2);
        pop   = m_valid && m_ready;

        fifo_cnt_nxt = fifo_cnt + CW'(push) - CW'(pop);
        inflight_nxt = inflight + CW'(rd_go && (phase == 2'd0)) - CW'(push);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        case (state)
            IDLE: begin
                if (start) state_nxt = zero_dim ? DONE : RUN;
            end
            RUN: begin
                busy        = 1'b1;
                mem_rd_en   = rd_go;
                mem_rd_addr = rd_go ? (row_addr + col_off) : '0;
                if (rd_go && last_byte) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Look ahead so done follows the final transfer by one cycle.
                if ((fifo_cnt_nxt == '0) && (inflight_nxt == '0)) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (!start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ret_valid <= 1'b0;
            ret_phase <= '0;
            ret_flags <= '0;
            b_q       <= '0;
            g_q       <= '0;
            stride    <= '0;
            row_bytes <= '0;
            row_addr  <= '0;
            col_off   <= '0;
            height_q  <= '0;
            row_cnt   <= '0;
            phase     <= '0;
            fifo_cnt  <= '0;
            inflight  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            ret_valid <= rd_go;
            ret_phase <= phase;
            ret_flags <= {sof_i, eol_i, eof_i};
            fifo_cnt  <= fifo_cnt_nxt;
            inflight  <= inflight_nxt;

            if (state == IDLE && start) begin
                stride    <= stride_in;
                row_bytes <= 32'(img_width) * 32'd3;
                row_addr  <= first_row;
                height_q  <= img_height;
                col_off   <= '0;
                row_cnt   <= '0;
                phase     <= '0;
            end

            if (rd_go) begin
                phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
                if (last_col) begin
                    col_off  <= '0;
                    row_addr <= row_addr - stride;
                    row_cnt  <= row_cnt + 16'd1;
                end else begin
                    col_off <= col_off + 32'd1;
                end
            end

            if (ret_valid && ret_phase == 2'd0) b_q <= mem_rd_data;
            if (ret_valid && ret_phase == 2'd1) g_q <= mem_rd_data;

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) fifo_mem[wr_ptr] <= {ret_flags, mem_rd_data, g_q, b_q};
    end

    always_comb begin
        head    = fifo_mem[rd_ptr];
        m_valid = (fifo_cnt != '0);
        m_data  = m_valid ? head[23:0] : '0;
        m_sof   = m_valid && head[26];
        m_eol   = m_valid && head[25];
        m_eof   = m_valid && head[24];
    end

endmodule

// File: tb/tb_bmp_frame_streamer.sv
// Randomized bench for bmp_frame_streamer: frame memory model plus a queue-based
// reference that lists expected read addresses and pixels straight from the BMP layout.
module tb_bmp_frame_streamer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, start, mem_rd_en, m_valid, m_ready;
    logic [31:0] base_addr, mem_rd_addr;
    logic [15:0] img_width, img_height;
    logic        busy, done, m_sof, m_eol, m_eof;
    logic [7:0]  mem_rd_data;
    logic [23:0] m_data;

    bmp_frame_streamer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .img_width(img_width), .img_height(img_height), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_ov [logic [31:0]];

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        if (mem_ov.exists(a)) return mem_ov[a];
        h = a * 32'h9E37_79B1;
        return h[31:24] ^ h[7:0];
    endfunction

    always @(posedge clk)
        mem_rd_data <= mem_rd_en ? mem_byte(mem_rd_addr) : 8'($urandom);

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [31:0] exp_addr [$];
    logic [26:0] exp_pix  [$];
    int rel, reads, popped, first_rd, first_valid, eof_rel, done_rel;
    int ready_mode;
    bit drop_start, stall_prev;
    logic [26:0] prev_word;

    task automatic monitor();
        logic [26:0] word;
        word = {m_sof, m_eol, m_eof, m_data};
        if (mem_rd_en) begin
            reads++;
            if (first_rd < 0) first_rd = rel;
            if (exp_addr.size() == 0)
                check_eq("rd_extra", {32'h0, mem_rd_addr}, 64'hFFFF_FFFF_0000_0000);
            else
                check_eq("rd_addr", mem_rd_addr, exp_addr.pop_front());
            check_eq("room", 64'(((reads + 2) / 3 - popped) <= DEPTH), 1);
        end
        if (stall_prev) begin
            check_eq("hold_valid", m_valid, 1);
            check_eq("hold_data", word, prev_word);
        end
        stall_prev = m_valid && !m_ready;
        prev_word  = word;
        if (m_valid && first_valid < 0) first_valid = rel;
        if (m_valid && m_ready) begin
            popped++;
            if (exp_pix.size() == 0)
                check_eq("pix_extra", {37'h0, word}, 64'hFFFF_0000_0000_0000);
            else
                check_eq("pixel", word, exp_pix.pop_front());
            if (m_eof) eof_rel = rel;
        end
        if (done && done_rel < 0) done_rel = rel;
        if (ready_mode == 2 && first_valid >= 0 && rel == first_valid + 29)
            check_eq("bp_reads", 64'(reads <= 12), 1);
    endtask

    task automatic tick();
        @(negedge clk);
        rel++;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 3) != 0);
            default: m_ready = (first_valid < 0 || rel < first_valid + 30) ? 1'b0 : 1'b1;
        endcase
        if (drop_start && rel == 4) start = 1'b0;
        monitor();
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_rd_en"}, mem_rd_en, 0);
        check_eq({tag, "_rd_addr"}, mem_rd_addr, 0);
        check_eq({tag, "_valid"}, m_valid, 0);
        check_eq({tag, "_data"}, m_data, 0);
        check_eq({tag, "_flags"}, {m_sof, m_eol, m_eof}, 0);
    endtask

    task automatic run_frame(input int w, input int h, input logic [31:0] base,
                             input int mode, input bit drop, input int hold, input int rst_after);
        logic [31:0] stride, row, a;
        int n;
        n = w * h;
        stride = ((32'(w) * 32'd3) + 32'd3) & ~32'd3;
        exp_addr.delete();
        exp_pix.delete();
        for (int r = 0; r < h; r++) begin
            row = base + 32'(h - 1 - r) * stride;
            for (int c = 0; c < w; c++) begin
                a = row + 32'(3 * c);
                for (int k = 0; k < 3; k++) exp_addr.push_back(a + 32'(k));
                exp_pix.push_back({r == 0 && c == 0, c == w - 1, r == h - 1 && c == w - 1,
                                   mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)});
            end
        end
        rel = 0; reads = 0; popped = 0; stall_prev = 0;
        first_rd = -1; first_valid = -1; eof_rel = -1; done_rel = -1;
        ready_mode = mode;
        drop_start = drop;

        @(negedge clk);
        start = 1'b1; base_addr = base;
        img_width = 16'(w); img_height = 16'(h);
        m_ready = (mode == 2) ? 1'b0 : 1'b1;

        while (done_rel < 0 && rel < 3000) begin
            tick();
            if (rst_after > 0 && popped >= rst_after) break;
        end

        if (rst_after > 0) begin
            check_eq("rst_pixels", popped, rst_after);
            @(negedge clk);
            rst = 1'b1; start = 1'b0; m_ready = 1'b1;
            @(negedge clk);
            check_reset_vals("midrst");
            rst = 1'b0;
            repeat (3) begin
                @(negedge clk);
                check_eq("post_rst_valid", m_valid, 0);
                check_eq("post_rst_rd", mem_rd_en, 0);
            end
            return;
        end

        check_eq("done_seen", 64'(done_rel >= 0), 1);
        check_eq("busy_at_done", busy, 0);
        check_eq("pix_left", exp_pix.size(), 0);
        check_eq("rd_left", exp_addr.size(), 0);
        check_eq("reads", reads, 3 * n);
        if (n == 0) check_eq("done_rel_zero", done_rel, 1);
        else        check_eq("done_after_eof", done_rel, eof_rel + 1);
        if (mode == 0 && n > 0) begin
            check_eq("first_rd", first_rd, 1);
            check_eq("first_valid", first_valid, 5);
            check_eq("eof_rel", eof_rel, 3 * n + 2);
        end

        drop_start = 0;
        if (drop) begin
            tick();
            check_eq("done_pulse", done, 0);
        end else begin
            repeat (hold) begin
                tick();
                check_eq("done_hold", done, 1);
            end
            @(negedge clk);
            start = 1'b0;
            tick();
            check_eq("done_fall", done, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; m_ready = 1'b0;
        base_addr = '0; img_width = '0; img_height = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // 2x2 at 0x100, stride 8: bottom row bytes 11..16, top row 01..06
        for (int i = 0; i < 6; i++) begin
            mem_ov[32'h108 + 32'(i)] = 8'(8'h01 + i);
            mem_ov[32'h100 + 32'(i)] = 8'(8'h11 + i);
        end
        run_frame(2, 2, 32'h100, 0, 0, 2, 0);

        run_frame(5, 1, 32'h0000_4000 + ($urandom & 32'hFF), 0, 0, 1, 0);
        run_frame(0, 3, 32'h200, 0, 0, 2, 0);
        run_frame(4, 0, 32'h300, 0, 0, 1, 0);
        run_frame(4, 4, 32'h0001_0000, 2, 0, 10, 0);

        for (int i = 0; i < 8; i++)
            run_frame($urandom_range(1, 7), $urandom_range(1, 5), $urandom,
                      $urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);

        run_frame(3, 3, 32'h0002_0000, 0, 0, 0, 3);
        run_frame(3, 3, 32'h0002_0000, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
